booth_mul_r4: RTL and testbench

//  Iterative radix-4 Booth multiplier; successor to the radix-2 Booth unit used by the ALU.

---
 rtl/booth_pkg.sv | 43 ++++
 rtl/booth_r4_enc.sv | 36 +++
 rtl/booth_mul_r4.sv | 124 ++++++++++++
 tb/tb_booth_mul_r4.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared encodings for the iterative radix-4 Booth multiplier: operand modes,
// controller states and the partial-product selector produced by the recoder.
package booth_pkg;

    localparam logic [1:0] MODE_SS = 2'b00;
    localparam logic [1:0] MODE_SU = 2'b01;
    localparam logic [1:0] MODE_UU = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_P1M,
        SEL_P2M,
        SEL_N1M,
        SEL_N2M
    } sel_t;

    // Returns {a_signed, b_signed}; mode 11 behaves as unsigned*unsigned.
    function automatic logic [1:0] mode_signs(input logic [1:0] mode);
        case (mode)
            MODE_SS: return 2'b11;
            MODE_SU: return 2'b10;
            MODE_UU: return 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    function automatic sel_t booth_recode(input logic [2:0] bits);
        case (bits)
            3'b001, 3'b010: return SEL_P1M;
            3'b011:         return SEL_P2M;
            3'b100:         return SEL_N2M;
            3'b101, 3'b110: return SEL_N1M;
            default:        return SEL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth partial-product encoder. Negative multiples are returned as the
// one's complement plus a carry-in so the accumulator adder completes the negation.
module booth_r4_enc
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       bits_i,
    input  logic [WIDTH+1:0] m_i,
    output logic [WIDTH+3:0] pp_o,
    output logic             neg_o
);

    logic [WIDTH+3:0] m_ext;

    assign m_ext = {{2{m_i[WIDTH+1]}}, m_i};

    always_comb begin
        pp_o  = '0;
        neg_o = 1'b0;
        case (booth_recode(bits_i))
            SEL_P1M: pp_o = m_ext;
            SEL_P2M: pp_o = m_ext << 1;
            SEL_N1M: begin
                pp_o  = ~m_ext;
                neg_o = 1'b1;
            end
            SEL_N2M: begin
                pp_o  = ~(m_ext << 1);
                neg_o = 1'b1;
            end
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_r4.sv
// Iterative radix-4 Booth multiplier with valid/ready on both sides, zero-operand
// early exit and synchronous flush; one recoded step per cycle, WIDTH/2+1 steps.
module booth_mul_r4
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [1:0]         i_mode,
    input  logic [TAG_W-1:0]   i_tag,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_result,
    output logic [TAG_W-1:0]   o_tag
);

    localparam int unsigned N     = WIDTH / 2 + 1;
    localparam int unsigned CNT_W = $clog2(N) + 1;
    localparam int unsigned PW    = WIDTH + 2;
    localparam int unsigned AW    = WIDTH + 4;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      m_q, m_d;
    logic [PW-1:0]      q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    logic [1:0]         signs;
    logic [PW-1:0]      a_ext, b_ext;
    logic [AW-1:0]      pp, sum;
    logic               pp_neg;
    logic               accept;

    assign signs = mode_signs(i_mode);
    assign a_ext = {{2{signs[1] & i_a[WIDTH-1]}}, i_a};
    assign b_ext = {{2{signs[0] & i_b[WIDTH-1]}}, i_b};

    booth_r4_enc #(.WIDTH(WIDTH)) u_enc (
        .bits_i ({q_q[1:0], qm1_q}),
        .m_i    (m_q),
        .pp_o   (pp),
        .neg_o  (pp_neg)
    );

    assign sum = acc_q + pp + AW'(pp_neg);

    // DONE re-opens the request side in the same cycle the result is taken.
    assign o_ready  = !i_rst && (state_q == ST_IDLE || (state_q == ST_DONE && i_ready));
    assign accept   = i_valid && o_ready && !i_flush;
    assign o_valid  = (state_q == ST_DONE);
    assign o_result = res_q;
    assign o_tag    = tag_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        acc_d   = acc_q;
        res_d   = res_q;
        tag_d   = tag_q;
        if (i_flush) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            tag_d = i_tag;
            m_d   = a_ext;
            q_d   = b_ext;
            qm1_d = 1'b0;
            acc_d = '0;
            cnt_d = '0;
            if (i_a == '0 || i_b == '0) begin
                state_d = ST_DONE;
                res_d   = '0;
            end else begin
                state_d = ST_BUSY;
            end
        end else if (state_q == ST_BUSY) begin
            acc_d = {{2{sum[AW-1]}}, sum[AW-1:2]};
            q_d   = {sum[1:0], q_q[PW-1:2]};
            qm1_d = q_q[1];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) begin
                state_d = ST_DONE;
                res_d   = {acc_d[WIDTH-3:0], q_d};
            end
        end else if (state_q == ST_DONE && i_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            acc_q   <= '0;
            res_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: tb/tb_booth_mul_r4.sv
// Self-checking bench for booth_mul_r4: directed corner cases on a 32-bit instance
// and randomized traffic on 32-bit and 8-bit instances against a plain-arithmetic model.
module tb_booth_mul_r4;

    localparam int unsigned W  = 32;
    localparam int unsigned WS = 8;
    localparam int unsigned TW = 4;

    logic clk;
    logic rst, flush, v32, v8, rdy, sel8;
    logic [31:0] a, b;
    logic [1:0]  mode;
    logic [3:0]  tag;

    logic           ordy32, ovld32, ordy8, ovld8;
    logic [2*W-1:0] res32;
    logic [2*WS-1:0] res8;
    logic [TW-1:0]  otag32, otag8;

    logic        cur_ordy, cur_ovld;
    logic [63:0] cur_res;
    logic [3:0]  cur_tag;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    booth_mul_r4 #(.WIDTH(W), .TAG_W(TW)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(v32), .o_ready(ordy32),
        .i_a(a), .i_b(b), .i_mode(mode), .i_tag(tag),
        .o_valid(ovld32), .i_ready(rdy), .o_result(res32), .o_tag(otag32)
    );

    booth_mul_r4 #(.WIDTH(WS), .TAG_W(TW)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(v8), .o_ready(ordy8),
        .i_a(a[WS-1:0]), .i_b(b[WS-1:0]), .i_mode(mode), .i_tag(tag),
        .o_valid(ovld8), .i_ready(rdy), .o_result(res8), .o_tag(otag8)
    );

    assign cur_ordy = sel8 ? ordy8 : ordy32;
    assign cur_ovld = sel8 ? ovld8 : ovld32;
    assign cur_res  = sel8 ? {48'd0, res8} : res32;
    assign cur_tag  = sel8 ? otag8 : otag32;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Product of the operands as the mode interprets them, modulo 2^(2w).
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic [1:0] m, input int w);
        logic [63:0] lo, ax, bx, p;
        lo = (64'd1 << w) - 64'd1;
        ax = {32'd0, x} & lo;
        bx = {32'd0, y} & lo;
        if (m[1] == 1'b0 && x[w-1]) ax = ax | ~lo;
        if (m == 2'b00 && y[w-1]) bx = bx | ~lo;
        p = ax * bx;
        if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
        return p;
    endfunction

    function automatic logic [31:0] rand_opnd(input int w);
        logic [31:0] msk;
        msk = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return msk;
            2:       return 32'd1 << (w - 1);
            3:       return 32'd1;
            default: return $urandom & msk;
        endcase
    endfunction

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                         input logic [1:0] im, input logic [3:0] it);
        int g;
        g = 0;
        @(negedge clk);
        a = ia; b = ib; mode = im; tag = it;
        if (sel8) v8 = 1'b1; else v32 = 1'b1;
        #1;
        while (!cur_ordy && g < 50) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (!cur_ordy) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        v8 = 1'b0; v32 = 1'b0;
        // Scramble inputs after the accept edge; they must not leak into the result.
        a = ~ia; b = ~ib; mode = ~im; tag = ~it;
    endtask

    // lat = clock edges between the accept edge and o_valid becoming visible.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!cur_ovld && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!cur_ovld) check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic take_result(input int hold);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rdy = 1'b1;
        @(posedge clk);
        #1;
        rdy = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [1:0] im, input logic [3:0] it,
                          input logic [63:0] exp, input int exp_lat, input int hold);
        int lat;
        issue(ia, ib, im, it);
        wait_valid(lat);
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check(name, cur_res, exp);
        check({name, "_tag"}, 64'(cur_tag), 64'(it));
        take_result(hold);
    endtask

    initial begin
        int lat;
        logic seen;
        logic [31:0] ra, rb;
        logic [1:0]  rm;
        logic [3:0]  rt;

        rst = 1'b1; flush = 1'b0; v32 = 1'b0; v8 = 1'b0; rdy = 1'b0; sel8 = 1'b0;
        a = '0; b = '0; mode = '0; tag = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(ovld32), 64'd0);
        check("rst_result", res32, 64'd0);
        check("rst_tag", 64'(otag32), 64'd0);
        check("rst_ready", 64'(ordy32), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(ordy32), 64'd1);

        run_op("ss_neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 4'd5, 64'h0000_0000_0000_0001, 17, 0);
        run_op("uu_max",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 4'd3, 64'hFFFF_FFFE_0000_0001, 17, 0);
        run_op("su_max",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 4'd1, 64'hFFFF_FFFF_0000_0001, 17, 0);
        run_op("ss_min",  32'h8000_0000, 32'h8000_0000, 2'b00, 4'd7, 64'h4000_0000_0000_0000, 17, 0);
        run_op("mode11",  32'hFFFF_FFFF, 32'd2,         2'b11, 4'd8, 64'h0000_0001_FFFF_FFFE, 17, 0);
        run_op("zero_a",  32'd0,         32'h1234_5678, 2'b00, 4'd2, 64'd0, 0, 0);
        run_op("zero_b",  32'h1234_5678, 32'd0,         2'b01, 4'd4, 64'd0, 0, 0);

        // Backpressure, then a back-to-back accept in the release cycle.
        issue(32'hFFFF_FFFB, 32'd7, 2'b00, 4'd9);
        wait_valid(lat);
        check("bp_lat", 64'(lat), 64'd17);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_result", cur_res, 64'hFFFF_FFFF_FFFF_FFDD);
            check("bp_tag", 64'(cur_tag), 64'd9);
            check("bp_valid", 64'(ovld32), 64'd1);
            check("bp_ready", 64'(ordy32), 64'd0);
        end
        @(negedge clk);
        rdy = 1'b1; v32 = 1'b1; a = 32'd100; b = 32'hFFFF_FFFD; mode = 2'b00; tag = 4'hA;
        #1;
        check("b2b_ready", 64'(ordy32), 64'd1);
        @(posedge clk);
        #1;
        v32 = 1'b0; rdy = 1'b0;
        wait_valid(lat);
        check("b2b_lat", 64'(lat), 64'd17);
        check("b2b_result", cur_res, 64'hFFFF_FFFF_FFFF_FED4);
        check("b2b_tag", 64'(cur_tag), 64'hA);
        take_result(0);

        // Flush at cnt = 8.
        issue(32'h0001_2345, 32'h0000_6789, 2'b00, 4'd6);
        repeat (8) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_valid", 64'(ovld32), 64'd0);
        check("flush_ready", 64'(ordy32), 64'd1);
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (ovld32) seen = 1'b1;
        end
        check("flush_no_result", 64'(seen), 64'd0);

        // Flush together with a request drops the request.
        @(negedge clk);
        flush = 1'b1; v32 = 1'b1; a = 32'd5; b = 32'd5; mode = 2'b00;
        @(posedge clk);
        #1;
        flush = 1'b0; v32 = 1'b0;
        check("flush_drop_ready", 64'(ordy32), 64'd1);
        check("flush_drop_valid", 64'(ovld32), 64'd0);

        run_op("after_flush", 32'd3, 32'd7, 2'b00, 4'd3, 64'd21, 17, 0);

        // Reset in the middle of a multiply.
        issue(32'd7, 32'd9, 2'b00, 4'hC);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 64'(ordy32), 64'd0);
        @(posedge clk);
        #1;
        check("mid_rst_valid", 64'(ovld32), 64'd0);
        check("mid_rst_result", res32, 64'd0);
        check("mid_rst_tag", 64'(otag32), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_ready_after", 64'(ordy32), 64'd1);

        for (int i = 0; i < 1500; i++) begin
            ra = rand_opnd(W); rb = rand_opnd(W);
            rm = 2'($urandom_range(0, 3)); rt = 4'($urandom);
            run_op("rand32", ra, rb, rm, rt, ref_mul(ra, rb, rm, W),
                   (ra == 0 || rb == 0) ? 0 : 17, $urandom_range(0, 2));
        end

        sel8 = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            ra = rand_opnd(WS); rb = rand_opnd(WS);
            rm = 2'($urandom_range(0, 3)); rt = 4'($urandom);
            run_op("rand8", ra, rb, rm, rt, ref_mul(ra, rb, rm, WS),
                   (ra == 0 || rb == 0) ? 0 : 5, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
